// File: rtl/acc_init_rotate_if.sv
// Accumulator input-BRAM write bus between acc_init_rotate and the accumulator-update stage.
// Carries write enable/address/data, the single-cycle start to the stage and its done pulse back.
// master: acc_init_rotate (drives writes and start_acc); slave: accumulator stage (drives acc_done).
interface acc_init_rotate_if #(
    parameter int DATA_SIZE  = 27,
    parameter int RING_DEPTH = 10
);
    logic                  acc_we;
    logic [RING_DEPTH:0]   acc_addr;   // MSB 0: a-half, MSB 1: b-half
    logic [DATA_SIZE-1:0]  acc_data;
    logic                  start_acc;
    logic                  acc_done;

    modport master (
        output acc_we,
        output acc_addr,
        output acc_data,
        output start_acc,
        input  acc_done
    );

    modport slave (
        input  acc_we,
        input  acc_addr,
        input  acc_data,
        input  start_acc,
        output acc_done
    );
endinterface

// File: rtl/acc_init_rotate.sv
// Initial accumulator writer: a = 0, b = X^k * tv mod (X^N+1, Q), then kicks the accumulator stage.
// Latency: N clear writes, N rotated writes (2 cycles read-to-write), 2 flush cycles, kick, wait for acc_done, done.
// Backpressure: none on the write bus; start and tv writes are ignored while busy.
// Ports: clk, reset (async active-low), tv_we/tv_addr/tv_data (test-vector load, idle only),
//        start/rot_amount (run request, k latched on accept), acc (acc_init_rotate_if master),
//        busy, done; err (sticky misuse flag) only when ACC_INIT_ERR_EN is defined.
module acc_init_rotate #(
    parameter int                   DATA_SIZE  = 27,
    parameter int                   RING_DEPTH = 10,
    parameter logic [DATA_SIZE-1:0] MODULUS    = 27'd67043329
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tv_we,
    input  logic [RING_DEPTH-1:0]    tv_addr,
    input  logic [DATA_SIZE-1:0]     tv_data,
    input  logic                     start,
    input  logic [RING_DEPTH:0]      rot_amount,
    acc_init_rotate_if.master        acc,
    output logic                     busy,
    output logic                     done
`ifdef ACC_INIT_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int N = 1 << RING_DEPTH;
    localparam logic [RING_DEPTH-1:0] LAST = RING_DEPTH'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ROTATE,
        S_FLUSH,
        S_KICK,
        S_WAIT_ACC,
        S_FIN
    } state_t;

    state_t                  state;
    logic [RING_DEPTH-1:0]   cnt;
    logic [RING_DEPTH-1:0]   cnt_nxt;
    logic [RING_DEPTH:0]     k_q;

    // Multiplying by X^k moves source coefficient src to c = src + k (mod 2N);
    // wrapping past N flips the sign because X^N = -1.
    logic [RING_DEPTH:0]     src;
    logic [RING_DEPTH-1:0]   rd_idx;
    logic                    issue;

    logic [DATA_SIZE-1:0]    tv_mem [N];
    logic [DATA_SIZE-1:0]    rd_q;
    logic [DATA_SIZE-1:0]    neg_val;

    // Read-issue pipeline stage, aligned with rd_q
    logic                    p_vld;
    logic                    p_neg;
    logic [RING_DEPTH-1:0]   p_idx;

    assign cnt_nxt = cnt + 1'b1;
    assign src     = {1'b0, cnt} - k_q;
    assign rd_idx  = src[RING_DEPTH-1:0];
    assign issue   = (state == S_ROTATE);
    assign neg_val = MODULUS - rd_q;

    // Test-vector BRAM: contents survive reset, one-cycle read latency.
    always_ff @(posedge clk) begin
        if (tv_we && !busy) begin
            tv_mem[tv_addr] <= tv_data;
        end
        rd_q <= tv_mem[rd_idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            k_q           <= '0;
            p_vld         <= 1'b0;
            p_neg         <= 1'b0;
            p_idx         <= '0;
            acc.acc_we    <= 1'b0;
            acc.acc_addr  <= '0;
            acc.acc_data  <= '0;
            acc.start_acc <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef ACC_INIT_ERR_EN
            err           <= 1'b0;
`endif
        end else begin
            acc.acc_we    <= 1'b0;
            acc.acc_addr  <= '0;
            acc.acc_data  <= '0;
            acc.start_acc <= 1'b0;
            done          <= 1'b0;

            p_vld <= issue;
            p_neg <= src[RING_DEPTH];
            p_idx <= cnt;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q          <= rot_amount;
                        busy         <= 1'b1;
                        cnt          <= '0;
                        state        <= S_CLEAR;
                        // Outputs are registered, so the first a-half write is set up here
                        acc.acc_we   <= 1'b1;
                        acc.acc_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_ROTATE;
                    end else begin
                        cnt          <= cnt_nxt;
                        acc.acc_we   <= 1'b1;
                        acc.acc_addr <= {1'b0, cnt_nxt};
                    end
                end
                S_ROTATE: begin
                    cnt <= cnt_nxt;
                    if (cnt == LAST) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Two cycles drain the read and write-data registers
                    if (cnt[0]) begin
                        cnt           <= '0;
                        state         <= S_KICK;
                        acc.start_acc <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                S_KICK: begin
                    state <= S_WAIT_ACC;
                end
                S_WAIT_ACC: begin
                    if (acc.acc_done) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Rotated b-half write, two cycles after its read was issued.
            // A zero coefficient stays zero when negated instead of becoming Q.
            if (p_vld) begin
                acc.acc_we   <= 1'b1;
                acc.acc_addr <= {1'b1, p_idx};
                acc.acc_data <= (p_neg && (rd_q != '0)) ? neg_val : rd_q;
            end

`ifdef ACC_INIT_ERR_EN
            if (busy && (start || tv_we)) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_acc_init_rotate.sv
// Randomized self-checking bench for acc_init_rotate against a polynomial-level reference model.
// Latency: checks exact cycle positions of clear/rotate writes, start_acc and done.
// Backpressure: exercises ignored start / tv_we while busy and acc_done outside the wait window.
module tb_acc_init_rotate;

    localparam int DS = 27;
    localparam int RD = 10;
    localparam int N  = 1 << RD;
    localparam int Q  = 67043329;

    logic           clk;
    logic           reset;
    logic           tv_we;
    logic [RD-1:0]  tv_addr;
    logic [DS-1:0]  tv_data;
    logic           start;
    logic [RD:0]    rot_amount;
    logic           busy;
    logic           done;
`ifdef ACC_INIT_ERR_EN
    logic           err;
`endif

    acc_init_rotate_if #(.DATA_SIZE(DS), .RING_DEPTH(RD)) acc_bus ();

    acc_init_rotate #(.DATA_SIZE(DS), .RING_DEPTH(RD), .MODULUS(27'd67043329)) dut (
        .clk        (clk),
        .reset      (reset),
        .tv_we      (tv_we),
        .tv_addr    (tv_addr),
        .tv_data    (tv_data),
        .start      (start),
        .rot_amount (rot_amount),
        .acc        (acc_bus.master),
        .busy       (busy),
        .done       (done)
`ifdef ACC_INIT_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int model_tv [N];
    int exp_b    [N];
    int got_b    [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // b = X^k * tv in Z_Q[X]/(X^N+1): coefficient i lands on (i+k) mod 2N,
    // and anything landing in [N, 2N) wraps to position p-N with a sign flip.
    function automatic void compute_exp(input int k);
        for (int i = 0; i < N; i++) begin
            int p;
            p = (i + k) % (2 * N);
            if (p < N) exp_b[p] = model_tv[i];
            else       exp_b[p - N] = (model_tv[i] == 0) ? 0 : Q - model_tv[i];
        end
    endfunction

    task automatic load_tv(input bit random_vals);
        for (int i = 0; i < N; i++) begin
            int v;
            if (random_vals) v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, Q - 1));
            else             v = i + 1;
            @(negedge clk);
            tv_we   = 1'b1;
            tv_addr = RD'(i);
            tv_data = DS'(v);
            model_tv[i] = v;
        end
        @(negedge clk);
        tv_we = 1'b0;
    endtask

    task automatic write_tv(input int idx, input int v);
        @(negedge clk);
        tv_we   = 1'b1;
        tv_addr = RD'(idx);
        tv_data = DS'(v);
        model_tv[idx] = v;
        @(negedge clk);
        tv_we = 1'b0;
    endtask

    // One full run. Cycle 0 is the first cycle after start is accepted.
    task automatic do_run(input int k, input bit disturb, input bit fin_start);
        int we_cnt, na, nb, a_bad, b_order_bad, last_a, first_b;
        int ks_cyc, ad_cyc, done_cyc, dly, sacc_cnt, busy_low, busy_at_done, mism;
        bit seen_done;
        we_cnt = 0; na = 0; nb = 0; a_bad = 0; b_order_bad = 0; last_a = -1; first_b = -1;
        ks_cyc = -1; ad_cyc = -1; done_cyc = -1; sacc_cnt = 0; busy_low = 0; busy_at_done = -1;
        mism = 0; seen_done = 1'b0;
        dly = int'($urandom_range(1, 5));
        for (int i = 0; i < N; i++) got_b[i] = -1;
        compute_exp(k);

        @(negedge clk);
        start      = 1'b1;
        rot_amount = (RD+1)'(k);
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 3 * N && !seen_done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (acc_bus.acc_we) begin
                we_cnt++;
                if (!acc_bus.acc_addr[RD]) begin
                    if (int'(acc_bus.acc_addr[RD-1:0]) != na || acc_bus.acc_data != '0) a_bad++;
                    na++;
                    last_a = cyc;
                end else begin
                    if (int'(acc_bus.acc_addr[RD-1:0]) != nb) b_order_bad++;
                    if (first_b < 0) first_b = cyc;
                    got_b[acc_bus.acc_addr[RD-1:0]] = int'(acc_bus.acc_data);
                    nb++;
                end
            end
            if (acc_bus.start_acc) begin
                sacc_cnt++;
                if (ks_cyc < 0) ks_cyc = cyc;
            end
            if (done) begin
                seen_done    = 1'b1;
                done_cyc     = cyc;
                busy_at_done = int'(busy);
            end else if (!busy) begin
                busy_low++;
            end

            acc_bus.acc_done = 1'b0;
            start            = 1'b0;
            tv_we            = 1'b0;
            if (ks_cyc >= 0 && ad_cyc < 0 && cyc == ks_cyc + dly) begin
                acc_bus.acc_done = 1'b1;
                ad_cyc = cyc;
            end
            if (disturb) begin
                if (cyc == 10) acc_bus.acc_done = 1'b1;
                if (cyc == N + 100) begin
                    start      = 1'b1;
                    rot_amount = (RD+1)'($urandom_range(0, 2 * N - 1));
                end
                if (ks_cyc >= 0 && cyc == ks_cyc + 1) begin
                    tv_we   = 1'b1;
                    tv_addr = RD'(3);
                    tv_data = DS'(12345);
                end
            end
        end
        acc_bus.acc_done = 1'b0;
        tv_we = 1'b0;

        if (fin_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("fin_start_busy", busy, 0);
            @(negedge clk);
            check("fin_start_we", acc_bus.acc_we, 0);
            check("fin_start_busy2", busy, 0);
        end else begin
            @(negedge clk);
            check("idle_busy", busy, 0);
        end

        for (int i = 0; i < N; i++) if (got_b[i] != exp_b[i]) mism++;

        check("done_seen", seen_done, 1);
        check("we_total", we_cnt, 2 * N);
        check("a_count", na, N);
        check("a_bad", a_bad, 0);
        check("b_order", b_order_bad, 0);
        check("last_a_cyc", last_a, N - 1);
        check("first_b_cyc", first_b, N + 2);
        check("start_acc_cyc", ks_cyc, 2 * N + 2);
        check("start_acc_cnt", sacc_cnt, 1);
        check("done_lat", done_cyc, ad_cyc + 1);
        check("busy_at_done", busy_at_done, 0);
        check("busy_gap", busy_low, 0);
        check("b_data_mism", mism, 0);
    endtask

    initial begin
        reset            = 1'b0;
        tv_we            = 1'b0;
        tv_addr          = '0;
        tv_data          = '0;
        start            = 1'b0;
        rot_amount       = '0;
        acc_bus.acc_done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_we", acc_bus.acc_we, 0);
        check("rst_start_acc", acc_bus.start_acc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", acc_bus.acc_addr, 0);
`ifdef ACC_INIT_ERR_EN
        check("rst_err", err, 0);
`endif
        reset = 1'b1;

        load_tv(1'b0);

        do_run(0, 1'b0, 1'b0);
        check("k0_b5", got_b[5], 6);

        do_run(3, 1'b0, 1'b1);
        check("k3_b0", got_b[0], Q - 1022);
        check("k3_b2", got_b[2], Q - 1024);
        check("k3_b3", got_b[3], 1);
        check("k3_b1023", got_b[1023], 1021);

        write_tv(7, 0);
        do_run(1024, 1'b0, 1'b0);
        check("kN_b7", got_b[7], 0);
        check("kN_b8", got_b[8], Q - 9);

        write_tv(7, 8);
        do_run(2047, 1'b0, 1'b0);
        check("k2047_b0", got_b[0], 2);
        check("k2047_b1022", got_b[1022], 1024);
        check("k2047_b1023", got_b[1023], Q - 1);

`ifdef ACC_INIT_ERR_EN
        check("err_clean", err, 0);
`endif
        do_run(int'($urandom_range(0, 2 * N - 1)), 1'b1, 1'b0);
`ifdef ACC_INIT_ERR_EN
        check("err_set", err, 1);
`endif
        // tv[3] must still hold 4: the busy-time write was dropped
        do_run(0, 1'b0, 1'b0);
        check("tv_kept_b3", got_b[3], 4);

        load_tv(1'b1);
        for (int r = 0; r < 3; r++) do_run(int'($urandom_range(0, 2 * N - 1)), 1'b0, 1'b0);

        // Asynchronous reset in the middle of the rotate phase
        @(negedge clk);
        start      = 1'b1;
        rot_amount = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (N + 500) @(negedge clk);
        check("mid_we_before", acc_bus.acc_we, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_we", acc_bus.acc_we, 0);
        check("mid_rst_data", acc_bus.acc_data, 0);
        check("mid_rst_addr", acc_bus.acc_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_start_acc", acc_bus.start_acc, 0);
`ifdef ACC_INIT_ERR_EN
        check("mid_rst_err", err, 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        do_run(0, 1'b0, 1'b0);
        check("post_rst_b0", got_b[0], model_tv[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
